// File: rtl/sdram_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of a single SDRAM controller port.
// The granted master's bus is routed straight through; a stalled access is aborted after TIMEOUT cycles.
module sdram_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        wb_clk,
  input  logic        wb_rst,

  input  logic [31:0] m0_adr_i,
  input  logic [15:0] m0_dat_i,
  input  logic [1:0]  m0_sel_i,
  input  logic        m0_we_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  output logic [15:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,

  input  logic [31:0] m1_adr_i,
  input  logic [15:0] m1_dat_i,
  input  logic [1:0]  m1_sel_i,
  input  logic        m1_we_i,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  output logic [15:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,

  output logic [31:0] s_adr_o,
  output logic [15:0] s_dat_o,
  output logic [1:0]  s_sel_o,
  output logic        s_we_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  input  logic [15:0] s_dat_i,
  input  logic        s_ack_i
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic               last, last_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;

  logic req0, req1;
  logic busy, sel1;
  logic g_cyc, g_stb;
  logic cnt_hit, timeout_hit;

  // Request decode and currently-granted master's handshake
  always_comb begin
    req0        = m0_cyc_i & m0_stb_i;
    req1        = m1_cyc_i & m1_stb_i;
    busy        = (state == BUSY0) || (state == BUSY1);
    sel1        = (state == BUSY1);
    g_cyc       = sel1 ? m1_cyc_i : m0_cyc_i;
    g_stb       = sel1 ? m1_stb_i : m0_stb_i;
    cnt_hit     = (cnt == CNT_W'(TIMEOUT));
    timeout_hit = busy & g_cyc & cnt_hit & ~s_ack_i;
  end

  // State, round-robin pointer and wait counter
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state <= IDLE;
      last  <= 1'b1;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state: grant in IDLE, leave BUSY on ack, abandon or timeout
  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (req0 && (!req1 || last)) begin
          state_nxt = BUSY0;
          last_nxt  = 1'b0;
          cnt_nxt   = '0;
        end else if (req1) begin
          state_nxt = BUSY1;
          last_nxt  = 1'b1;
          cnt_nxt   = '0;
        end
      end
      BUSY0, BUSY1: begin
        if (!g_cyc || s_ack_i || cnt_hit) begin
          state_nxt = IDLE;
        end else if (cnt != '1) begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: route the granted master, qualify ack/err by ownership
  always_comb begin
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_sel_o  = '0;
    s_we_o   = 1'b0;
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    m0_ack_o = 1'b0;
    m1_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_err_o = 1'b0;
    m0_dat_o = s_dat_i;
    m1_dat_o = s_dat_i;
    if (busy) begin
      s_adr_o  = sel1 ? m1_adr_i : m0_adr_i;
      s_dat_o  = sel1 ? m1_dat_i : m0_dat_i;
      s_sel_o  = sel1 ? m1_sel_i : m0_sel_i;
      s_we_o   = sel1 ? m1_we_i  : m0_we_i;
      s_cyc_o  = g_cyc & g_stb & ~timeout_hit;
      s_stb_o  = g_cyc & g_stb & ~timeout_hit;
      m0_ack_o = ~sel1 & g_cyc & s_ack_i;
      m1_ack_o =  sel1 & g_cyc & s_ack_i;
      m0_err_o = ~sel1 & timeout_hit;
      m1_err_o =  sel1 & timeout_hit;
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed and randomized bench for sdram_arbiter against a transaction-level ownership model.
module tb_sdram_arbiter;

  localparam int TO = 4;

  logic        wb_clk = 1'b0;
  logic        wb_rst;
  logic [31:0] m_adr [2];
  logic [15:0] m_dat [2];
  logic [1:0]  m_sel [2];
  logic [1:0]  m_we, m_cyc, m_stb;
  logic [15:0] m_dat_o [2];
  logic [1:0]  m_ack, m_err;
  logic [31:0] s_adr_o;
  logic [15:0] s_dat_o;
  logic [1:0]  s_sel_o;
  logic        s_we_o, s_cyc_o, s_stb_o;
  logic [15:0] s_dat;
  logic        s_ack;

  sdram_arbiter #(.TIMEOUT(TO)) dut (
    .wb_clk  (wb_clk),
    .wb_rst  (wb_rst),
    .m0_adr_i(m_adr[0]), .m0_dat_i(m_dat[0]), .m0_sel_i(m_sel[0]), .m0_we_i(m_we[0]),
    .m0_cyc_i(m_cyc[0]), .m0_stb_i(m_stb[0]),
    .m0_dat_o(m_dat_o[0]), .m0_ack_o(m_ack[0]), .m0_err_o(m_err[0]),
    .m1_adr_i(m_adr[1]), .m1_dat_i(m_dat[1]), .m1_sel_i(m_sel[1]), .m1_we_i(m_we[1]),
    .m1_cyc_i(m_cyc[1]), .m1_stb_i(m_stb[1]),
    .m1_dat_o(m_dat_o[1]), .m1_ack_o(m_ack[1]), .m1_err_o(m_err[1]),
    .s_adr_o (s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cyc_o (s_cyc_o), .s_stb_o(s_stb_o),
    .s_dat_i (s_dat),   .s_ack_i(s_ack)
  );

  always #5 wb_clk = ~wb_clk;

  int errors = 0;
  int checks = 0;

  // Model: who owns the SDRAM port, since which cycle, and who was granted last
  int owner;
  int prev;
  int grant_at;
  int now;
  int grants[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    owner = -1;
    prev  = 1;
  endtask

  task automatic check_cycle();
    logic [31:0] e_adr;
    logic [15:0] e_dat;
    logic [1:0]  e_sel, e_ack, e_err;
    logic        e_we, e_cyc, o;
    bit          to;
    e_adr = '0; e_dat = '0; e_sel = '0; e_we = 1'b0; e_cyc = 1'b0;
    e_ack = '0; e_err = '0;
    if (owner >= 0) begin
      o     = owner[0];
      to    = ((now - grant_at) == TO) && !s_ack;
      e_adr = m_adr[o];
      e_dat = m_dat[o];
      e_sel = m_sel[o];
      e_we  = m_we[o];
      e_cyc = m_cyc[o] && m_stb[o] && !to;
      e_ack[o] = m_cyc[o] && s_ack;
      e_err[o] = m_cyc[o] && to;
    end
    chk("s_adr", s_adr_o, e_adr);
    chk("s_dat", 32'(s_dat_o), 32'(e_dat));
    chk("s_sel", 32'(s_sel_o), 32'(e_sel));
    chk("s_we",  32'(s_we_o),  32'(e_we));
    chk("s_cyc", 32'(s_cyc_o), 32'(e_cyc));
    chk("s_stb", 32'(s_stb_o), 32'(e_cyc));
    chk("ack",   32'(m_ack),   32'(e_ack));
    chk("err",   32'(m_err),   32'(e_err));
    chk("dat0",  32'(m_dat_o[0]), 32'(s_dat));
    chk("dat1",  32'(m_dat_o[1]), 32'(s_dat));
  endtask

  task automatic advance();
    int g;
    bit v0, v1;
    v0 = m_cyc[0] && m_stb[0];
    v1 = m_cyc[1] && m_stb[1];
    if (owner < 0) begin
      g = -1;
      if (v0 && v1) g = (prev == 0) ? 1 : 0;
      else if (v0)  g = 0;
      else if (v1)  g = 1;
      if (g >= 0) begin
        owner    = g;
        prev     = g;
        grant_at = now + 1;
        grants.push_back(g);
      end
    end else if (!m_cyc[owner[0]] || s_ack || ((now - grant_at) == TO)) begin
      owner = -1;
    end
  endtask

  task automatic cycle();
    @(negedge wb_clk);
    check_cycle();
    advance();
    @(posedge wb_clk);
    #1;
    now++;
  endtask

  task automatic idle_inputs();
    for (int n = 0; n < 2; n++) begin
      m_adr[n] = 32'h1000_0000 * (n + 1);
      m_dat[n] = 16'h1111 * 16'(n + 1);
      m_sel[n] = 2'b11;
    end
    m_we  = '0;
    m_cyc = '0;
    m_stb = '0;
    s_ack = 1'b0;
    s_dat = 16'(0);
  endtask

  task automatic do_reset();
    wb_rst = 1'b1;
    idle_inputs();
    s_dat = 16'h5A5A;
    #1;
    chk("rst_cyc", 32'(s_cyc_o), 32'd0);
    chk("rst_adr", s_adr_o, 32'd0);
    chk("rst_ack", 32'(m_ack), 32'd0);
    chk("rst_err", 32'(m_err), 32'd0);
    chk("rst_dat", 32'(m_dat_o[1]), 32'h5A5A);
    @(posedge wb_clk);
    #1;
    wb_rst = 1'b0;
    model_reset();
  endtask

  initial begin
    now = 0;
    model_reset();
    do_reset();

    // m0 read, ack in the 4th busy cycle with 0xBEEF
    m_adr[0] = 32'h0001_2344; m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    cycle();
    repeat (3) cycle();
    s_ack = 1'b1; s_dat = 16'hBEEF;
    #1;
    chk("r28_ack0", 32'(m_ack[0]), 32'd1);
    chk("r28_dat0", 32'(m_dat_o[0]), 32'hBEEF);
    chk("r28_ack1", 32'(m_ack[1]), 32'd0);
    chk("r28_adr",  s_adr_o, 32'h0001_2344);
    cycle();
    s_ack = 1'b0; m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    cycle();

    // Continuous dual request alternates, starting with m0
    do_reset();
    grants.delete();
    m_cyc = 2'b11; m_stb = 2'b11;
    for (int i = 0; i < 12; i++) begin
      s_ack = (owner >= 0) && ((now - grant_at) == 1);
      cycle();
    end
    chk("r29_count", 32'(grants.size()), 32'd4);
    for (int i = 0; i < grants.size(); i++) chk("r29_order", 32'(grants[i]), 32'(i % 2));
    idle_inputs();
    cycle();

    // m1 write never acked: error on 5th busy cycle, then m0 is served
    do_reset();
    m_we[1] = 1'b1; m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    cycle();
    repeat (TO) cycle();
    #1;
    chk("r30_err1", 32'(m_err[1]), 32'd1);
    chk("r30_cyc",  32'(s_cyc_o), 32'd0);
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    cycle();
    m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    cycle();
    chk("r30_m0", s_adr_o, m_adr[0]);
    s_ack = 1'b1;
    cycle();
    idle_inputs();
    cycle();

    // m0 abandons the cycle while the slave acks
    do_reset();
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    cycle();
    cycle();
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0; s_ack = 1'b1;
    #1;
    chk("r31_ack0", 32'(m_ack[0]), 32'd0);
    cycle();
    s_ack = 1'b0;
    cycle();

    // Reset pulse mid-cycle during BUSY1
    do_reset();
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    cycle();
    s_ack = 1'b1;
    #1;
    chk("r32_pre_ack1", 32'(m_ack[1]), 32'd1);
    #1 wb_rst = 1'b1;
    #1;
    chk("r32_cyc",  32'(s_cyc_o), 32'd0);
    chk("r32_ack1", 32'(m_ack[1]), 32'd0);
    wb_rst = 1'b0;
    model_reset();
    s_ack = 1'b0;
    m_cyc = 2'b11; m_stb = 2'b11;
    cycle();
    chk("r32_grant", s_adr_o, m_adr[0]);
    s_ack = 1'b1;
    cycle();
    idle_inputs();
    cycle();

    // Ack on the timeout cycle wins
    do_reset();
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    cycle();
    repeat (TO) cycle();
    s_ack = 1'b1;
    #1;
    chk("r33_ack0", 32'(m_ack[0]), 32'd1);
    chk("r33_err0", 32'(m_err[0]), 32'd0);
    chk("r33_cyc",  32'(s_cyc_o), 32'd1);
    cycle();
    idle_inputs();
    cycle();

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      for (int n = 0; n < 2; n++) begin
        if (owner == n) m_cyc[n] = ($urandom_range(0, 15) != 0);
        else            m_cyc[n] = ($urandom_range(0, 1) == 1);
        m_stb[n] = m_cyc[n];
        m_adr[n] = $urandom;
        m_dat[n] = 16'($urandom);
        m_sel[n] = 2'($urandom);
        m_we[n]  = 1'($urandom);
      end
      s_dat = 16'($urandom);
      s_ack = ((i / 40) % 2 == 1) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 3) == 0);
      cycle();
    end
    idle_inputs();
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, giving the cycles a granted access may wait for s_ack_i before abort (range 1..255).
REQ-002 SHALL have port wb_clk  in  1  sole clock; all state on rising edge.
REQ-003 SHALL have port wb_rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports mN_adr_i  in  32  byte address from requester N (N=0 CPU/EMS-translated, N=1 video/DMA).
REQ-005 SHALL have ports mN_dat_i  in  16  write data; mN_sel_i  in  2  byte lanes; mN_we_i  in  1  write strobe.
REQ-006 SHALL have ports mN_cyc_i, mN_stb_i  in  1 each  Wishbone request.
REQ-007 SHALL have ports mN_dat_o  out  16  read data; mN_ack_o  out  1  done; mN_err_o  out  1  timeout abort.
REQ-008 SHALL have ports s_adr_o  out  32, s_dat_o  out  16, s_sel_o  out  2, s_we_o  out  1, s_cyc_o  out  1, s_stb_o  out  1  to SDRAM controller.
REQ-009 SHALL have ports s_dat_i  in  16, s_ack_i  in  1  from SDRAM controller.

Function
REQ-010 SHALL implement states IDLE, BUSY0, BUSY1 plus 1-bit register last (last granted requester) and 8-bit wait counter.
REQ-011 In IDLE, request N valid = mN_cyc_i & mN_stb_i; s_cyc_o = s_stb_o = 0.
REQ-012 In IDLE with one valid request, SHALL move to BUSYN on next edge, set last=N, clear counter.
REQ-013 In IDLE with both valid, SHALL grant the requester != last (round-robin); tie at reset goes to m0.
REQ-014 In BUSYN, s_adr_o/s_dat_o/s_sel_o/s_we_o SHALL combinationally follow mN_*; s_cyc_o = s_stb_o = mN_cyc_i & mN_stb_i.
REQ-015 Outside BUSY, s_adr_o/s_dat_o/s_sel_o/s_we_o SHALL be 0.
REQ-016 mN_ack_o SHALL equal s_ack_i only while in BUSYN; otherwise 0. Non-granted requester never sees ack or err.
REQ-017 mN_dat_o SHALL equal s_dat_i for both N (broadcast); only ack qualifies it.
REQ-018 On s_ack_i in BUSYN, SHALL return to IDLE next edge; minimum grant-to-grant gap 1 IDLE cycle.
REQ-019 Grant latency: request sampled in IDLE at edge k, s_stb_o high after edge k; ack earliest same cycle.
REQ-020 Counter SHALL increment each BUSY cycle without s_ack_i; saturates, no wrap.
REQ-021 When counter == TIMEOUT and s_ack_i = 0, SHALL assert mN_err_o for that one cycle, drop s_cyc_o/s_stb_o that cycle, return to IDLE.
REQ-022 s_ack_i and timeout in same cycle: ack wins, err = 0.
REQ-023 If granted requester drops mN_cyc_i in BUSYN, SHALL return to IDLE next edge, no ack/err; s_ack_i arriving that cycle is discarded.
REQ-024 last SHALL update only on grant, not on completion or abort.

Reset
REQ-025 While wb_rst = 1 (asynchronous), state = IDLE, last = 1, counter = 0; all outputs 0 (s_*_o, mN_ack_o, mN_err_o) except mN_dat_o = s_dat_i.
REQ-026 Reset asserted mid-transaction SHALL immediately drop s_cyc_o and any ack/err; no pending grant survives.
REQ-027 After wb_rst deasserts, first grant SHALL occur no earlier than the first rising edge with wb_rst = 0.

Verification
REQ-028 m0 read, adr 0x0001_2344, slave acks 3 cycles after stb with s_dat_i 0xBEEF -> m0_ack_o one cycle, m0_dat_o 0xBEEF, m1_ack_o 0.
REQ-029 m0 and m1 both request continuously, slave acks after 1 cycle -> grants alternate 0,1,0,1 starting with m0, one IDLE cycle between.
REQ-030 TIMEOUT=4, m1 write, slave never acks -> m1_err_o pulses on 5th BUSY cycle, s_cyc_o low that cycle, next m0 request granted.
REQ-031 m0 granted, m0_cyc_i drops before ack, s_ack_i same cycle -> no m0_ack_o, IDLE next edge.
REQ-032 wb_rst pulsed mid-clock during BUSY1 -> s_cyc_o and m1_ack_o low before next edge; next simultaneous request grants m0.
REQ-033 s_ack_i and counter == TIMEOUT in same cycle -> ack delivered, err 0.
